hit_frontend: RTL and testbench

//  - Conditions the asynchronous detector 'hit' input before it reaches the counting/memory core.
//  - Synchronises the input and detects rising edges.
//  - Applies a programmable dead time after each accepted hit.
//  - Emits a single-cycle hit_valid strobe that the core's counter consumes.
//  - Counts hits rejected during dead time, for readout alongside the core's data.

---
 rtl/hit_frontend.sv | 173 +++++++++++++++++
 tb/tb_hit_frontend.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hit_frontend.sv
// hit_frontend: conditions the asynchronous detector hit input for the counting core.
// Synchronises hit, detects rising edges, enforces a programmable dead time after
// each accepted hit, and counts hits rejected during dead time.
//
// Optional feature macro: HIT_FRONTEND_GLITCH_FILTER_EN
//   defined   -> an edge needs hs high on two consecutive cycles after a low (0,1,1);
//                adds one cycle of latency and drops 1-cycle pulses.
//   undefined -> plain single-sample rising-edge detect.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   hit       raw asynchronous detector hit
//   mode      3'b001 = DATA_TAKING; anything else returns the FSM to IDLE
//   clr_lost  synchronous clear of lost_cnt (wins over an increment)
//   hit_valid 1-cycle strobe per accepted hit
//   hit_lost  1-cycle strobe per hit rejected during dead time
//   dead      high while the dead-time window is active
//   armed     high while the FSM is not IDLE
//   lost_cnt  saturating count of rejected hits
module hit_frontend #(
  parameter int unsigned DATA_BITS   = 12,
  parameter int unsigned DEAD_CYCLES = 8,
  parameter int unsigned SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hit,
  input  logic [2:0]           mode,
  input  logic                 clr_lost,
  output logic                 hit_valid,
  output logic                 hit_lost,
  output logic                 dead,
  output logic                 armed,
  output logic [DATA_BITS-1:0] lost_cnt
);

  localparam int unsigned CTR_W     = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int unsigned DEAD_INIT = (DEAD_CYCLES > 0) ? (DEAD_CYCLES - 1) : 0;
`ifdef HIT_FRONTEND_GLITCH_FILTER_EN
  localparam int unsigned HIST_W    = 2;
`else
  localparam int unsigned HIST_W    = 1;
`endif
  localparam int unsigned VLD_W     = SYNC_STAGES + HIST_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_DEAD  = 2'd2;

  localparam logic [2:0] MODE_DATA = 3'b001;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hs;
  logic                   hs_d;
  logic [VLD_W-1:0]       vld_q;
  logic                   hit_edge;

  logic [1:0]           state_q, state_n;
  logic [CTR_W-1:0]     ctr_q, ctr_n;
  logic                 valid_n, lost_n, dead_n, armed_n;
  logic [DATA_BITS-1:0] lcnt_n;

  assign hs = sync_q[SYNC_STAGES-1];

  // Synchroniser, edge history, and a fill marker so that a hit already high at
  // reset release is not mistaken for a rising edge (history flops reset to 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hs_d   <= 1'b0;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], hit};
      hs_d   <= hs;
      vld_q  <= {vld_q[VLD_W-2:0], 1'b1};
    end
  end

`ifdef HIT_FRONTEND_GLITCH_FILTER_EN
  logic hs_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hs_d2 <= 1'b0;
    else        hs_d2 <= hs_d;
  end

  // Edge only after the pattern low, high, high.
  assign hit_edge = hs & hs_d & ~hs_d2 & vld_q[VLD_W-1];
`else
  assign hit_edge = hs & ~hs_d & vld_q[VLD_W-1];
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ctr_q     <= '0;
      hit_valid <= 1'b0;
      hit_lost  <= 1'b0;
      dead      <= 1'b0;
      armed     <= 1'b0;
      lost_cnt  <= '0;
    end else begin
      state_q   <= state_n;
      ctr_q     <= ctr_n;
      hit_valid <= valid_n;
      hit_lost  <= lost_n;
      dead      <= dead_n;
      armed     <= armed_n;
      lost_cnt  <= lcnt_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state_q;
    ctr_n   = ctr_q;
    valid_n = 1'b0;
    lost_n  = 1'b0;
    dead_n  = dead;
    lcnt_n  = lost_cnt;

    case (state_q)
      S_IDLE: begin
        dead_n = 1'b0;
        ctr_n  = '0;
        if (mode == MODE_DATA) state_n = S_ARMED;
      end
      S_ARMED: begin
        if (mode != MODE_DATA) begin
          state_n = S_IDLE;
          dead_n  = 1'b0;
          ctr_n   = '0;
        end else if (hit_edge) begin
          valid_n = 1'b1;
          if (DEAD_CYCLES > 0) begin
            state_n = S_DEAD;
            dead_n  = 1'b1;
            ctr_n   = CTR_W'(DEAD_INIT);
          end
        end
      end
      S_DEAD: begin
        if (mode != MODE_DATA) begin
          state_n = S_IDLE;
          dead_n  = 1'b0;
          ctr_n   = '0;
        end else begin
          if (hit_edge) begin
            lost_n = 1'b1;
            if (!(&lost_cnt)) lcnt_n = lost_cnt + DATA_BITS'(1);
          end
          if (ctr_q == '0) begin
            state_n = S_ARMED;
            dead_n  = 1'b0;
          end else begin
            ctr_n = ctr_q - CTR_W'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        dead_n  = 1'b0;
        ctr_n   = '0;
      end
    endcase

    if (clr_lost) lcnt_n = '0;
    armed_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_hit_frontend.sv
// Scoreboard bench for hit_frontend: the stimulus thread pushes expected strobes
// (kind, cycle, lost_cnt) and a negedge monitor pops and compares them.
module tb_hit_frontend;

  localparam int unsigned DB = 4;
  localparam int unsigned DC = 8;
  localparam int unsigned SS = 2;
`ifdef HIT_FRONTEND_GLITCH_FILTER_EN
  localparam int L  = SS + 2;
  localparam int PW = 2;
`else
  localparam int L  = SS + 1;
  localparam int PW = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hit = 1'b0;
  logic [2:0]    mode = 3'b001;
  logic          clr_lost = 1'b0;
  logic          hit_valid, hit_lost, dead, armed;
  logic [DB-1:0] lost_cnt;

  hit_frontend #(.DATA_BITS(DB), .DEAD_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .hit(hit), .mode(mode), .clr_lost(clr_lost),
    .hit_valid(hit_valid), .hit_lost(hit_lost), .dead(dead), .armed(armed),
    .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int kind;  // 1 = hit_valid, 2 = hit_lost
    int at;
    int lc;
  } ev_t;
  ev_t q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int at, input int lc);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.lc   = lc;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic hit_at(input int base, input int off, input int width);
    wait_cyc(base + off);
    hit = 1'b1;
    repeat (width) @(negedge clk);
    hit = 1'b0;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (hit_valid || hit_lost) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", int'({hit_lost, hit_valid}), 0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("strobe_kind", int'({hit_lost, hit_valid}), e.kind);
        chk("strobe_cycle", cyc, e.at);
        chk("strobe_lost_cnt", int'(lost_cnt), e.lc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int exp_lost;
    exp_lost = 0;

    // Reset with hit high and mode DATA_TAKING
    hit = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hit_valid", int'(hit_valid), 0);
    chk("rst_hit_lost", int'(hit_lost), 0);
    chk("rst_dead", int'(dead), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_lost_cnt", int'(lost_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("armed_after_release", int'(armed), 1);
    repeat (6) @(negedge clk);
    hit = 1'b0;
    repeat (3) @(negedge clk);

    // Latency and dead-window length
    base = cyc + 2;
    expect_ev(1, base + L, exp_lost);
    hit_at(base, 0, PW);
    wait_cyc(base + L - 1);
    chk("dead_before_hit", int'(dead), 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dead) n++;
    end
    chk("dead_length", n, DC);

    // Dead time: accept, lose, then accept in first cycle back
    base = cyc + 2;
    expect_ev(1, base + L, exp_lost);
    hit_at(base, 0, PW);
    exp_lost = sat_inc(exp_lost);
    expect_ev(2, base + 4 + L, exp_lost);
    hit_at(base, 4, PW);
    expect_ev(1, base + 9 + L, exp_lost);
    hit_at(base, 9, PW);
    wait_cyc(base + 9 + L + DC + 2);
    chk("lost_after_dead_test", int'(lost_cnt), 1);

    // Asynchronous reset in the middle of a dead window
    base = cyc + 2;
    expect_ev(1, base + L, exp_lost);
    hit_at(base, 0, PW);
    wait_cyc(base + L + 2);
    chk("dead_before_async_rst", int'(dead), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_dead", int'(dead), 0);
    chk("async_rst_armed", int'(armed), 0);
    chk("async_rst_lost_cnt", int'(lost_cnt), 0);
    exp_lost = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Mode exit during dead time
    base = cyc + 2;
    expect_ev(1, base + L, exp_lost);
    hit_at(base, 0, PW);
    exp_lost = sat_inc(exp_lost);
    expect_ev(2, base + 3 + L, exp_lost);
    hit_at(base, 3, PW);
    wait_cyc(base + L + 4);
    chk("mode_exit_armed_before", int'(armed), 1);
    chk("mode_exit_dead_before", int'(dead), 1);
    mode = 3'b010;
    @(negedge clk);
    chk("mode_exit_dead", int'(dead), 0);
    chk("mode_exit_armed", int'(armed), 0);
    hit_at(base, 10, PW);
    hit_at(base, 14, PW);
    wait_cyc(base + 22);
    chk("mode_read_lost_hold", int'(lost_cnt), 1);
    chk("mode_read_armed", int'(armed), 0);
    mode = 3'b001;
    repeat (3) @(negedge clk);
    chk("rearm", int'(armed), 1);

    // Saturation: 18 lost hits into a 4-bit counter
    clr_lost = 1'b1;
    @(negedge clk);
    clr_lost = 1'b0;
    chk("clr_lost", int'(lost_cnt), 0);
    exp_lost = 0;
    for (int w = 0; w < 9; w++) begin
      base = cyc + 2;
      expect_ev(1, base + L, exp_lost);
      hit_at(base, 0, PW);
      exp_lost = sat_inc(exp_lost);
      expect_ev(2, base + 3 + L, exp_lost);
      hit_at(base, 3, PW);
      exp_lost = sat_inc(exp_lost);
      expect_ev(2, base + 6 + L, exp_lost);
      hit_at(base, 6, PW);
      wait_cyc(base + 9);
    end
    wait_cyc(cyc + L + DC + 2);
    chk("saturated", int'(lost_cnt), 15);

    // Clear coinciding with a lost hit
    base = cyc + 2;
    expect_ev(1, base + L, 15);
    hit_at(base, 0, PW);
    expect_ev(2, base + 3 + L, 0);
    hit_at(base, 3, PW);
    wait_cyc(base + 3 + L - 1);
    clr_lost = 1'b1;
    @(negedge clk);
    clr_lost = 1'b0;
    chk("clr_wins", int'(lost_cnt), 0);
    @(negedge clk);
    chk("clr_hold", int'(lost_cnt), 0);
    exp_lost = 0;
    wait_cyc(base + L + DC + 4);

    // Short pulse (dropped only with the glitch filter), then a 3-cycle pulse
    base = cyc + 2;
`ifndef HIT_FRONTEND_GLITCH_FILTER_EN
    expect_ev(1, base + L, exp_lost);
`endif
    hit_at(base, 0, 1);
    base = base + 14;
    expect_ev(1, base + L, exp_lost);
    hit_at(base, 0, 3);
    wait_cyc(base + L + DC + 4);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
